// File: rtl/ysyx_22040386_pkg.sv
// Shared FSM encoding, bus response codes and reset defaults for the ysyx_22040386 IFU.
package ysyx_22040386_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned INST_W           = 32;

  // Width of the lane index for a MEM_DW-wide beat; kept >= 1 so ports never collapse.
  function automatic int unsigned lane_sel_w(input int unsigned mem_dw);
    return (mem_dw > INST_W) ? $clog2(mem_dw / INST_W) : 1;
  endfunction

endpackage

// File: rtl/ysyx_22040386_ifu_lane_sel.sv
// Picks the 32-bit instruction lane out of a MEM_DW-wide read beat (lane 0 = bits 31:0).
module ysyx_22040386_ifu_lane_sel
  import ysyx_22040386_pkg::*;
#(
  parameter int unsigned MEM_DW = 64
) (
  input  logic [MEM_DW-1:0]               data,
  input  logic [lane_sel_w(MEM_DW)-1:0]   lane,
  output logic [INST_W-1:0]               inst_c
);

  localparam int unsigned LANES = MEM_DW / INST_W;

  logic [LANES-1:0][INST_W-1:0] words;

  assign words = data;

  generate
    if (LANES == 1) begin : g_single
      logic unused_lane;
      assign unused_lane = ^lane;
      assign inst_c      = words[0];
    end else begin : g_multi
      assign inst_c = words[lane];
    end
  endgenerate

endmodule

// File: rtl/ysyx_22040386_ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches over an AR/R bus and hands instructions to the IDU.
// Optional fetch-fault reporting is enabled by defining YSYX_22040386_IFU_FAULT_EN.
module ysyx_22040386_ifu_fetch
  import ysyx_22040386_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned MEM_DW   = 64,
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              i_IFU_clk,
  input  logic              i_IFU_rst,
  input  logic              i_IFU_redirect,
  input  logic [XLEN-1:0]   i_IFU_dnpc,
  output logic              o_IFU_arvalid,
  input  logic              i_IFU_arready,
  output logic [XLEN-1:0]   o_IFU_araddr,
  input  logic              i_IFU_rvalid,
  output logic              o_IFU_rready,
  input  logic [MEM_DW-1:0] i_IFU_rdata,
  input  logic [1:0]        i_IFU_rresp,
  output logic              o_IFU_valid,
  input  logic              i_IFU_ready,
  output logic [XLEN-1:0]   o_IFU_pc,
  output logic [31:0]       o_IFU_inst,
  output logic              o_IFU_fault
);

  localparam int unsigned     SEL_W  = lane_sel_w(MEM_DW);
  localparam logic [XLEN-1:0] PC_RST = XLEN'(RESET_PC);

  logic [1:0]        state_q, state_n;
  logic [XLEN-1:0]   pc_q, pc_n;
  logic              drop_q, drop_n;
  logic [31:0]       inst_q, inst_n;
  logic              fault_q, fault_n;
  logic [31:0]       lane_inst_c;
  logic              misaligned_c;
  logic              resp_fault_c;
  logic              ar_hs_c;

`ifdef YSYX_22040386_IFU_FAULT_EN
  assign misaligned_c = (pc_q[1:0] != 2'b00);
  assign resp_fault_c = (i_IFU_rresp != RESP_OKAY);
`else
  logic unused_rresp;
  assign unused_rresp = ^i_IFU_rresp;
  assign misaligned_c = 1'b0;
  assign resp_fault_c = 1'b0;
`endif

  ysyx_22040386_ifu_lane_sel #(
    .MEM_DW (MEM_DW)
  ) u_lane_sel (
    .data   (i_IFU_rdata),
    .lane   (pc_q[SEL_W+1:2]),
    .inst_c (lane_inst_c)
  );

  // A misaligned PC never reaches the bus when fault reporting is enabled.
  assign o_IFU_arvalid = (state_q == ST_REQ) && !misaligned_c;
  assign o_IFU_rready  = (state_q == ST_WAIT);
  assign o_IFU_valid   = (state_q == ST_HOLD);
  assign o_IFU_araddr  = pc_q;
  assign o_IFU_pc      = pc_q;
  assign o_IFU_inst    = inst_q;
  assign o_IFU_fault   = (state_q == ST_HOLD) && fault_q;

  assign ar_hs_c = o_IFU_arvalid && i_IFU_arready;

  // Next-state logic; a redirect always retargets the PC, and any response
  // belonging to the old stream is discarded via drop.
  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    drop_n  = drop_q;
    inst_n  = inst_q;
    fault_n = fault_q;
    case (state_q)
      ST_IDLE: begin
        state_n = ST_REQ;
        if (i_IFU_redirect) pc_n = i_IFU_dnpc;
      end
      ST_REQ: begin
        if (i_IFU_redirect) begin
          pc_n = i_IFU_dnpc;
          if (ar_hs_c) begin
            drop_n  = 1'b1;
            state_n = ST_WAIT;
          end
        end else if (misaligned_c) begin
          inst_n  = '0;
          fault_n = 1'b1;
          state_n = ST_HOLD;
        end else if (ar_hs_c) begin
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_IFU_redirect) pc_n = i_IFU_dnpc;
        if (i_IFU_rvalid) begin
          if (drop_q || i_IFU_redirect) begin
            drop_n  = 1'b0;
            state_n = ST_REQ;
          end else begin
            inst_n  = lane_inst_c;
            fault_n = resp_fault_c;
            state_n = ST_HOLD;
          end
        end else if (i_IFU_redirect) begin
          drop_n = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_IFU_redirect) begin
          pc_n    = i_IFU_dnpc;
          state_n = ST_REQ;
        end else if (i_IFU_ready) begin
          pc_n    = pc_q + XLEN'(4);
          state_n = ST_REQ;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_IFU_clk) begin
    if (i_IFU_rst) begin
      state_q <= ST_IDLE;
      pc_q    <= PC_RST;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      drop_q  <= drop_n;
      inst_q  <= inst_n;
      fault_q <= fault_n;
    end
  end

endmodule
